// File: rtl/xor_pkg.sv
// Shared types for the XOR chaining encryptor output path.
package xor_pkg;

    localparam int unsigned BLK_W_DEFAULT = 256;
    localparam int unsigned BLK_BYTES     = BLK_W_DEFAULT / 8;

    typedef logic [7:0]                     xor_byte_t;
    typedef logic [$clog2(BLK_BYTES)-1:0]   byte_idx_t;

    typedef enum logic {
        StIdle,
        StSend
    } ser_state_e;

endpackage

// File: rtl/xor_blk_fifo.sv
// Pointer-based synchronous block FIFO; pointers carry an extra wrap bit for full/empty.
module xor_blk_fifo #(
    parameter int unsigned Width = 256,
    parameter int unsigned Depth = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] wdata_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(Depth);

    logic [AW:0]      wptr_q, rptr_q;
    logic [Width-1:0] mem_q [Depth];

    // Pointer registers; a simultaneous push and pop on a full FIFO keeps occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + 1'b1;
            if (pop_i)  rptr_q <= rptr_q + 1'b1;
        end
    end

    // Storage needs no reset; the pointers alone decide what is valid.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q[AW-1:0]];
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

endmodule

// File: rtl/xor_block_serializer.sv
// Buffers ciphertext blocks and streams them out byte 0 first on a valid/ready interface.
module xor_block_serializer
    import xor_pkg::*;
#(
    parameter int unsigned BLK_W = 256,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         blk_valid_i,
    input  logic [BLK_W-1:0]             blk_data_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output xor_byte_t                    out_data_o,
    output logic [$clog2(BLK_W/8)-1:0]   out_idx_o,
    output logic                         out_last_o,
    output logic                         busy_o,
    output logic                         ovf_err_o,
    input  logic                         clr_err_i
);

    localparam int unsigned BlkBytes = BLK_W / 8;
    localparam int unsigned IdxW     = $clog2(BlkBytes);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(BlkBytes - 1);

    ser_state_e       state_q, state_d;
    logic [BLK_W-1:0] shreg_q, shreg_d;
    logic [IdxW-1:0]  cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic             push, pop, drop, full, empty;
    logic [BLK_W-1:0] rdata;

    xor_blk_fifo #(
        .Width (BLK_W),
        .Depth (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (blk_data_i),
        .rdata_o (rdata),
        .full_o  (full),
        .empty_o (empty)
    );

    // Pop frees a slot in the same cycle, so a full FIFO still accepts when popping.
    assign push = blk_valid_i && (!full || pop);
    assign drop = blk_valid_i && full && !pop;

    // Next-state: load from FIFO when idle or on the last-byte handshake, else shift.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        pop         = 1'b0;
        out_valid_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shreg_d = rdata;
                    cnt_d   = '0;
                    state_d = StSend;
                end
            end
            StSend: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    if (cnt_q != LastIdx) begin
                        shreg_d = shreg_q >> 8;
                        cnt_d   = cnt_q + 1'b1;
                    end else if (!empty) begin
                        pop     = 1'b1;
                        shreg_d = rdata;
                        cnt_d   = '0;
                    end else begin
                        // Clear so idle outputs read 0 rather than stale bytes.
                        shreg_d = '0;
                        cnt_d   = '0;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Sticky overflow flag; a drop wins over a simultaneous clear.
    always_comb begin
        ovf_d = ovf_q;
        if (drop)           ovf_d = 1'b1;
        else if (clr_err_i) ovf_d = 1'b0;
    end

    // State, datapath and error registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            shreg_q <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_data_o = shreg_q[7:0];
    assign out_idx_o  = cnt_q;
    assign out_last_o = (state_q == StSend) && (cnt_q == LastIdx);
    assign busy_o     = (state_q == StSend) || !empty;
    assign ovf_err_o  = ovf_q;

endmodule

// File: tb/tb_xor_block_serializer.sv
module tb_xor_block_serializer;

    localparam int unsigned BLK_W = 256;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned NBYTE = BLK_W / 8;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             blk_valid = 1'b0;
    logic [BLK_W-1:0] blk_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [7:0]       out_data;
    logic [4:0]       out_idx;
    logic             out_last;
    logic             busy;
    logic             ovf_err;
    logic             clr_err = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    xor_block_serializer #(
        .BLK_W (BLK_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .blk_valid_i (blk_valid),
        .blk_data_i  (blk_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_idx_o   (out_idx),
        .out_last_o  (out_last),
        .busy_o      (busy),
        .ovf_err_o   (ovf_err),
        .clr_err_i   (clr_err)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a queue of waiting blocks plus the block being sent.
    logic [BLK_W-1:0] pend[$];
    logic [BLK_W-1:0] m_cur  = '0;
    bit               m_val  = 1'b0;
    int               m_idx  = 0;
    bit               m_ovf  = 1'b0;
    bit               m_hs, m_pop, m_drop;

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend.delete();
            m_cur = '0;
            m_val = 1'b0;
            m_idx = 0;
            m_ovf = 1'b0;
        end else begin
            m_hs   = m_val && out_ready;
            m_pop  = (pend.size() > 0) && (!m_val || (m_hs && m_idx == NBYTE - 1));
            m_drop = blk_valid && (pend.size() == DEPTH) && !m_pop;
            if (m_pop) begin
                m_cur = pend.pop_front();
                m_idx = 0;
                m_val = 1'b1;
            end else if (m_hs) begin
                if (m_idx == NBYTE - 1) begin
                    m_val = 1'b0;
                    m_idx = 0;
                end else begin
                    m_idx++;
                end
            end
            if (blk_valid && !m_drop) pend.push_back(blk_data);
            if (m_drop)       m_ovf = 1'b1;
            else if (clr_err) m_ovf = 1'b0;
        end
    end

    // Cycle-by-cycle comparison; byte fields only matter while a byte is offered.
    always @(negedge clk_i) begin
        logic [16:0] got, exp;
        logic [7:0]  eb;
        eb  = m_cur[8*m_idx +: 8];
        exp = {m_val, m_val ? eb : 8'h0, m_val ? 5'(m_idx) : 5'h0,
               m_val && (m_idx == NBYTE - 1), m_val || (pend.size() > 0), m_ovf};
        got = {out_valid, m_val ? out_data : 8'h0, m_val ? out_idx : 5'h0,
               m_val ? out_last : 1'b0, busy, ovf_err};
        check_eq("cycle", 64'(got), 64'(exp));
    end

    logic [7:0] got_q[$];
    logic [7:0] last_q[$];

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic pulse(input logic [BLK_W-1:0] d);
        blk_valid = 1'b1;
        blk_data  = d;
        tick();
        blk_valid = 1'b0;
    endtask

    function automatic logic [BLK_W-1:0] rand_blk();
        logic [BLK_W-1:0] b;
        for (int i = 0; i < BLK_W / 32; i++) b[32*i +: 32] = $urandom;
        return b;
    endfunction

    // Drain with ready held high, collecting every offered byte.
    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        out_ready = 1'b1;
        while (busy && n < max_cyc) begin
            if (out_valid) begin
                got_q.push_back(out_data);
                if (out_last) last_q.push_back(out_data);
            end
            tick();
            n++;
        end
        if (busy) check_eq("drain_timeout", 1, 0);
    endtask

    function automatic int cmp_stream(input logic [BLK_W-1:0] blks[$]);
        int errs;
        errs = 0;
        if (got_q.size() != blks.size() * NBYTE) return 9999;
        for (int b = 0; b < blks.size(); b++)
            for (int i = 0; i < NBYTE; i++)
                if (got_q[b*NBYTE + i] !== blks[b][8*i +: 8]) errs++;
        return errs;
    endfunction

    initial begin
        logic [BLK_W-1:0] blks[$];
        logic [BLK_W-1:0] b;
        int run, maxrun, nval, n;

        // Reset state
        repeat (3) tick();
        check_eq("reset_outs", 64'({out_valid, out_data, out_idx, out_last, busy, ovf_err}), 0);
        rst_ni = 1'b1;
        tick();

        // Single block, byte i = i
        for (int i = 0; i < NBYTE; i++) b[8*i +: 8] = 8'(i);
        out_ready = 1'b1;
        pulse(b);
        check_eq("lat_early_valid", 64'(out_valid), 0);
        tick();
        check_eq("lat_valid", 64'(out_valid), 1);
        check_eq("lat_first", 64'({out_data, out_idx}), 0);
        got_q.delete();
        last_q.delete();
        drain(100);
        blks = '{b};
        check_eq("single_bytes", 64'(cmp_stream(blks)), 0);
        check_eq("single_last_cnt", 64'(last_q.size()), 1);
        if (last_q.size() == 1) check_eq("single_last_byte", 64'(last_q[0]), 64'h1F);

        // Back-to-back blocks 32 cycles apart
        run = 0; maxrun = 0; nval = 0;
        for (int k = 0; k < 3; k++) begin
            b = (k == 0) ? {32{8'hA5}} : (k == 1) ? {32{8'h5A}} : {32{8'hFF}};
            blk_valid = 1'b1;
            blk_data  = b;
            for (int c = 0; c < NBYTE; c++) begin
                tick();
                blk_valid = 1'b0;
                if (out_valid) begin nval++; run++; if (run > maxrun) maxrun = run; end
                else run = 0;
            end
        end
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
            if (out_valid) begin nval++; run++; if (run > maxrun) maxrun = run; end
            else run = 0;
        end
        check_eq("b2b_run", 64'(maxrun), 96);
        check_eq("b2b_total", 64'(nval), 96);
        check_eq("b2b_ovf", 64'(ovf_err), 0);

        // Backpressure on one block
        b = rand_blk();
        got_q.delete();
        pulse(b);
        n = 0;
        while ((busy || got_q.size() == 0) && n < 400) begin
            out_ready = 1'($urandom_range(1));
            if (out_valid && out_ready) got_q.push_back(out_data);
            tick();
            n++;
        end
        blks = '{b};
        check_eq("bp_bytes", 64'(cmp_stream(blks)), 0);

        // Overflow: four consecutive pulses with ready low
        out_ready = 1'b0;
        blks.delete();
        for (int k = 0; k < 4; k++) begin
            b = rand_blk();
            blks.push_back(b);
            pulse(b);
            blk_valid = (k < 3);
        end
        blk_valid = 1'b0;
        tick();
        check_eq("ovf_set", 64'(ovf_err), 1);
        void'(blks.pop_back());
        got_q.delete();
        drain(400);
        check_eq("ovf_count", 64'(got_q.size()), 96);
        check_eq("ovf_bytes", 64'(cmp_stream(blks)), 0);

        // Clear, then drop and clear in the same cycle
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check_eq("clr_plain", 64'(ovf_err), 0);
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            blk_valid = 1'b1;
            blk_data  = rand_blk();
            clr_err   = (k == 3);
            tick();
        end
        blk_valid = 1'b0;
        clr_err   = 1'b0;
        tick();
        check_eq("prio_set_wins", 64'(ovf_err), 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check_eq("prio_clr_later", 64'(ovf_err), 0);
        drain(400);

        // Reset in the middle of a block, with the error flag raised
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            blk_valid = 1'b1;
            blk_data  = rand_blk();
            tick();
        end
        blk_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (!(out_valid && out_idx == 5'd10) && n < 100) begin tick(); n++; end
        check_eq("rst_reach_byte10", 64'(out_idx), 10);
        #2 rst_ni = 1'b0;
        #1 check_eq("rst_async", 64'({out_valid, busy, ovf_err, out_last, out_data, out_idx}), 0);
        tick();
        rst_ni = 1'b1;
        tick();
        b = rand_blk();
        got_q.delete();
        pulse(b);
        tick();
        check_eq("rst_new_idx", 64'({out_valid, out_idx}), 64'h20);
        drain(100);
        blks = '{b};
        check_eq("rst_new_bytes", 64'(cmp_stream(blks)), 0);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            blk_valid = ($urandom_range(23) == 0);
            blk_data  = rand_blk();
            out_ready = ($urandom_range(3) != 0);
            clr_err   = ($urandom_range(49) == 0);
            tick();
        end
        blk_valid = 1'b0;
        clr_err   = 1'b0;
        drain(1000);
        check_eq("final_idle", 64'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/xor_block_serializer.md
# xor_block_serializer

Downstream stage of the 256-bit XOR chaining encryptor. It captures each registered ciphertext block (one-cycle `valid` pulse, no backpressure) into a small block FIFO. It then streams the block out byte-by-byte, byte 0 (bits 7:0) first, on a valid/ready byte interface toward the transport. Because the encryptor cannot be stalled, overflow drops whole blocks and raises a sticky error.

## Interface
- `BLK_W`, 256: block width in bits; must be a multiple of 8.
- `DEPTH`, 2: block FIFO entries; power of 2, ≥ 2.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `blk_valid` in 1: one-cycle pulse; `blk_data` is valid this cycle.
- `blk_data` in BLK_W: ciphertext block.
- `out_valid` out 1: byte available.
- `out_ready` in 1: consumer accepts the byte.
- `out_data` out 8: current byte.
- `out_idx` out $clog2(BLK_W/8): index of the current byte within its block.
- `out_last` out 1: current byte is the final byte of its block (index BLK_W/8−1).
- `busy` out 1: FIFO non-empty or FSM in SEND.
- `ovf_err` out 1: sticky flag; a block was dropped.
- `clr_err` in 1: synchronous clear of `ovf_err`.

## Operation
- **Block FIFO (DEPTH entries)**
  - `push = blk_valid && (!full || pop)`.
  - `blk_valid && full && !pop` drops the block and sets `ovf_err`.
  - Set has priority over `clr_err` in the same cycle.
- **Shift register** `shreg[BLK_W-1:0]` and byte counter `cnt`.
  - `out_data = shreg[7:0]`.
  - `out_idx = cnt`.
  - `out_last = (cnt == BLK_W/8-1)`.
- **FSM states**
  - **IDLE**
    - `out_valid = 0`.
    - If FIFO not empty: pop the head into `shreg`, set `cnt = 0`, and go to SEND.
  - **SEND**
    - `out_valid = 1`.
    - On handshake (`out_valid && out_ready`), when `cnt != last`: `shreg >>= 8` and `cnt++`.
    - On handshake with `cnt == last` and FIFO not empty: pop the next block into `shreg` in the same edge and set `cnt = 0`. No bubble between blocks.
    - On handshake with `cnt == last` and FIFO empty: go to IDLE.
- A pop is a load into `shreg` (IDLE load or last-byte reload).
- A push and pop in the same cycle on a full FIFO are both performed; occupancy is unchanged.
- Total buffering is DEPTH + 1 blocks (FIFO plus `shreg`).
- **Output stability rule:** while `out_valid && !out_ready`, the values of `out_data`, `out_idx` and `out_last` are held stable. `out_valid` never drops without a handshake.
- `out_valid` does not depend combinationally on `out_ready`.
- **Reset** (async, any time)
  - FIFO is emptied; FSM goes to IDLE; `shreg` and `cnt` are cleared; `ovf_err` is cleared.
  - Any partially sent block is discarded.
  - All outputs read 0 during reset and immediately after it.

## Timing
- A `blk_valid` pulse sampled at edge E, with the FSM IDLE and the FIFO empty, gives the first byte `out_valid = 1` in the cycle after edge E+1. Latency is 2 cycles.
- With `out_ready` held at 1: one byte per cycle, and a block occupies exactly BLK_W/8 = 32 cycles.
- Sustained input of one block per 32 cycles never overflows.
- Bursts are absorbed up to DEPTH + 1 blocks.
- `ovf_err` rises in the cycle after the dropping edge.
- `clr_err` takes effect at the next edge.
- `busy` is registered-state derived. It is 0 exactly when IDLE and the FIFO is empty.

## Structure
- **Shared package** `xor_pkg`:
  - `BLK_BYTES = BLK_W/8` (32).
  - `typedef logic [7:0] xor_byte_t`.
  - `typedef logic [$clog2(BLK_BYTES)-1:0] byte_idx_t`.
  - FSM enum `ser_state_e` with values {IDLE, SEND}.
- **Sub-module** `xor_blk_fifo`:
  - Parameterised width/depth synchronous FIFO with `rst_n`.
  - Ports `push`, `pop`, `wdata`, `rdata`, `full`, `empty`.
  - Pointer-based, with an extra wrap bit per pointer.
- The top level contains the FSM, `shreg`, `cnt` and the error logic.

## Test plan
- **Single block:** `blk_data` byte i = i (0x1F1E…0100), `out_ready = 1`.
  - First byte 0x00 with `out_idx = 0`, 2 cycles after the pulse.
  - Bytes 0x00…0x1F appear on consecutive cycles.
  - `out_last = 1` only on 0x1F.
  - `busy` drops the cycle after that byte.
- **Back-to-back:** three pulses 32 cycles apart (patterns 0xA5…, 0x5A…, 0xFF…), `out_ready = 1`.
  - 96 consecutive `out_valid` cycles with no bubble.
  - `ovf_err = 0`.
- **Backpressure:** random `out_ready` (50%) on one block.
  - `out_data`, `out_idx` and `out_last` hold while stalled.
  - All 32 bytes are delivered in order; none duplicated or skipped.
- **Overflow:** `out_ready = 0`, four pulses on consecutive cycles with DEPTH = 2.
  - Blocks 1–3 are retained and block 4 is dropped.
  - `ovf_err = 1`.
  - After releasing `out_ready`, exactly 96 bytes come out (blocks 1, 2, 3).
- **Error priority:** `clr_err = 1` in the same cycle as a drop.
  - `ovf_err` stays 1.
  - `clr_err` alone on a later cycle clears it to 0.
- **Reset mid-block:** assert `rst_n = 0` at byte 10 of a block.
  - `out_valid`, `busy` and `ovf_err` go 0 asynchronously.
  - After release, a new pulse produces bytes starting at `out_idx = 0` with the new data only.
